mat_result_reader: RTL and testbench



---
 rtl/mat_pkg.sv | 17 +
 rtl/result_skid_fifo.sv | 68 ++++++
 rtl/mat_result_reader.sv | 141 ++++++++++++++
 tb/tb_mat_result_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared constants and reader state encoding for the matrix multiply slice.
package mat_pkg;

  // Result word width (MAC accumulator width), output RAM address width,
  // and number of C words produced by one multiply.
  localparam int MAT_DATA_W = 19;
  localparam int MAT_ADDR_W = 8;
  localparam int MAT_DEPTH  = 64;

  // Result reader control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } reader_state_e;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry skid FIFO. The head entry always sits in head_r, so the
// read side sees a plain register that holds steady until it is popped.
module result_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic [1:0]   count_r;

  // Shift-style storage: the oldest entry lives in head_r, the newer in tail_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r  <= push_data;
            count_r <= 2'd1;
          end else if (count_r == 2'd1) begin
            tail_r  <= push_data;
            count_r <= 2'd2;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_r  <= tail_r;
            count_r <= 2'd1;
          end else if (count_r == 2'd1) begin
            count_r <= 2'd0;
          end
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            head_r <= tail_r;
            tail_r <= push_data;
          end else begin
            // With one entry the popped head is replaced in place; a pop of
            // an empty FIFO is meaningless and degrades to a plain push.
            head_r  <= push_data;
            count_r <= 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head  = head_r;
  assign count = count_r;
  assign empty = (count_r == 2'd0);
  assign full  = (count_r == 2'd2);

endmodule

// File: rtl/mat_result_reader.sv
// Drains the result matrix C from the output RAM after a multiply and
// streams it out on a valid/ready interface, absorbing the 1-cycle RAM
// read latency with a 2-entry skid FIFO.
module mat_result_reader
  import mat_pkg::*;
#(
  parameter int DATA_W = MAT_DATA_W,
  parameter int ADDR_W = MAT_ADDR_W,
  parameter int DEPTH  = MAT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int                FW       = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  reader_state_e     state_r;
  reader_state_e     state_nxt_s;
  logic [ADDR_W:0]   rd_cnt_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic              rd_pending_r;
  logic              busy_r;
  logic              done_r;

  logic              issue_s;
  logic              pop_s;
  logic              push_s;
  logic [2:0]        occ_s;
  logic [FW-1:0]     head_s;
  logic [1:0]        fifo_count_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  assign out_valid = !fifo_empty_s;
  assign out_index = head_s[FW-1:DATA_W];
  assign out_data  = head_s[DATA_W-1:0];
  assign out_last  = out_valid && (out_index == LAST_IDX);
  assign pop_s     = out_valid && out_ready;

  // Words held plus the read still in flight; issuing must keep this at most 2.
  assign occ_s  = {1'b0, fifo_count_s} + {2'b00, rd_pending_r};
  // The FIFO is never full while a read is pending; the guard only keeps a
  // broken invariant from corrupting the stored head.
  assign push_s = rd_pending_r && (!fifo_full_s || pop_s);

  // Read issue decision: more words to fetch and room for the returning word.
  always_comb begin
    issue_s = 1'b0;
    if ((state_r == ST_RUN) && (rd_cnt_r < DEPTH_C) &&
        (occ_s < (3'd2 + {2'b00, pop_s}))) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign mem_re   = issue_s;
  assign mem_addr = issue_s ? rd_cnt_r[ADDR_W-1:0] : last_addr_r;

  // Next-state logic: a drain ends on the transfer of the last index.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pop_s && out_last) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, read counter, pending-read flag and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      rd_cnt_r     <= '0;
      last_addr_r  <= '0;
      rd_pending_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s == ST_RUN);
      done_r       <= (state_nxt_s == ST_DONE);
      rd_pending_r <= issue_s;
      if ((state_r == ST_IDLE) && start) begin
        rd_cnt_r <= '0;
      end else if (issue_s) begin
        rd_cnt_r    <= rd_cnt_r + (ADDR_W + 1)'(1);
        last_addr_r <= rd_cnt_r[ADDR_W-1:0];
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;

  // The address of a returning word is the last one issued.
  result_skid_fifo #(
    .W (FW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({last_addr_r, mem_rdata}),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

endmodule

// File: tb/tb_mat_result_reader.sv
// Directed, table-driven bench for mat_result_reader with a 1-cycle RAM model.
module tb_mat_result_reader;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] ram [0:255];
  logic [DATA_W-1:0] cap [0:DEPTH-1];
  int n_cmp;
  int n_err;

  typedef struct {
    int duty;
    int start_at;
    bit start_in_done;
    int reset_at;
    bit ext_pat;
    int exp_xfer;
    int exp_done;
  } run_vec_t;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] val;
  } ext_vec_t;

  run_vec_t vecs [6];
  ext_vec_t ext  [3];

  mat_result_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output RAM: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_re"},    32'(mem_re),    32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_index"}, 32'(out_index), 32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
  endtask

  task automatic run_drain(input run_vec_t v, output int n_xfer, output int n_done);
    int                issued;
    int                last_cyc;
    int                done_cyc;
    bit                hold;
    bit                start_sent;
    bit                pop;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] hold_idx;
    issued     = 0;
    n_xfer     = 0;
    n_done     = 0;
    last_cyc   = -100;
    done_cyc   = -1;
    hold       = 1'b0;
    start_sent = 1'b0;
    hold_data  = '0;
    hold_idx   = '0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      out_ready = (v.duty >= 100) ? 1'b1 : ($urandom_range(99) < 32'(v.duty));
      if (v.start_at >= 0 && n_xfer == v.start_at && !start_sent) begin
        start      = 1'b1;
        start_sent = 1'b1;
      end
      #1;
      pop = out_valid && out_ready;
      if (cyc == 0) begin
        check("first_mem_re",   32'(mem_re),    32'd1);
        check("first_mem_addr", 32'(mem_addr),  32'd0);
        check("first_busy",     32'(busy),      32'd1);
        check("valid_before_e1", 32'(out_valid), 32'd0);
      end
      if (cyc == 1) check("valid_before_e2", 32'(out_valid), 32'd0);
      if (cyc == 2) begin
        check("valid_from_e2", 32'(out_valid), 32'd1);
        check("first_index",   32'(out_index), 32'd0);
      end
      if (v.reset_at >= 0 && n_xfer == v.reset_at) begin
        reset = 1'b1;
        #1;
        check_all_zero("abort_rst");
        #1;
        reset = 1'b0;
        repeat (6) begin
          @(negedge clk);
          #1;
          check("no_done_after_abort", 32'(done), 32'd0);
          if (done) n_done++;
        end
        return;
      end
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data",  32'(out_data),  32'(hold_data));
        check("hold_index", 32'(out_index), 32'(hold_idx));
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_index;
      if (mem_re) begin
        check("issue_room", 32'((issued - n_xfer - int'(pop)) < 2), 32'd1);
        check("issue_addr", 32'(mem_addr), 32'(issued));
        issued++;
      end
      if (out_valid) check("last_flag", 32'(out_last), 32'(out_index == 8'd63));
      if (pop) begin
        check("xfer_index", 32'(out_index), 32'(n_xfer));
        check("xfer_data",  32'(out_data),  32'(ram[n_xfer[7:0]]));
        if (v.duty >= 100 && n_xfer > 0) check("no_bubble", 32'(cyc - last_cyc), 32'd1);
        if (n_xfer < DEPTH) cap[n_xfer] = out_data;
        last_cyc = cyc;
        n_xfer++;
      end
      if (done) begin
        n_done++;
        check("done_after_last", 32'(cyc - last_cyc), 32'd1);
        check("busy_low_in_done", 32'(busy), 32'd0);
        done_cyc = cyc;
        if (v.start_in_done) start = 1'b1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;

    //          duty start_at in_done reset_at ext   xfer done
    vecs[0] = '{100, -1,      1'b0,   -1,      1'b0, 64,  1};
    vecs[1] = '{30,  -1,      1'b0,   -1,      1'b0, 64,  1};
    vecs[2] = '{100, 10,      1'b1,   -1,      1'b0, 64,  1};
    vecs[3] = '{100, -1,      1'b0,   20,      1'b0, 20,  0};
    vecs[4] = '{100, -1,      1'b0,   -1,      1'b0, 64,  1};
    vecs[5] = '{50,  -1,      1'b0,   -1,      1'b1, 64,  1};

    ext[0] = '{0,  19'h7FFFF};
    ext[1] = '{1,  19'h40000};
    ext[2] = '{63, 19'h00001};

    for (int i = 0; i < 256; i++) ram[i] = DATA_W'(i * 1000);

    repeat (3) @(negedge clk);
    check_all_zero("por");
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("idle");

    for (int k = 0; k < 6; k++) begin
      int nx;
      int nd;
      if (vecs[k].ext_pat) begin
        for (int j = 0; j < 3; j++) ram[ext[j].idx] = ext[j].val;
      end
      run_drain(vecs[k], nx, nd);
      check("xfer_count", 32'(nx), 32'(vecs[k].exp_xfer));
      check("done_count", 32'(nd), 32'(vecs[k].exp_done));
    end

    for (int j = 0; j < 3; j++) check("extreme_value", 32'(cap[ext[j].idx]), 32'(ext[j].val));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
